pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the architectural PC and fetches instructions from instruction memory.
//  Delivers {instr, pc, pc_plus} to decode. Accepts the resolved next PC back
//  from the branch-resolution stage: npc is BranchControl NPC, pc_plus is its
//  PC_plus. One instruction in flight (multi-cycle core), no speculation.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be word aligned
//  ADDR_W    32             PC / address width
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  ADDR_W  fetch address (= pc)
//  imem_rsp_valid  in   1       instruction word returned (1-cycle pulse)
//  imem_rsp_data   in   32      instruction word
//  ir_valid        out  1       instruction available to decode
//  ir_ready        in   1       decode accepts instruction
//  ir              out  32      instruction word
//  pc              out  ADDR_W  PC of ir
//  pc_plus         out  ADDR_W  pc + 4, modulo 2^ADDR_W
//  npc_valid       in   1       execute done, npc resolved
//  npc             in   ADDR_W  next PC from branch resolution
//  halt            in   1       stop fetching (sticky until reset)
//  misalign        out  1       sticky: npc[1:0] != 0 was accepted
//  fetch_cnt       out  32      retired fetch count (FETCH_PERF_EN)
//  mem_wait_cnt    out  32      cycles in WAIT_RSP (FETCH_PERF_EN)
// BEHAVIOUR
//  Reset (async assert, sync release): state=REQ, pc=RESET_PC, ir=0,
//   all valids 0, misalign=0, counters 0. An in-flight response is discarded.
//  States: REQ -> WAIT_RSP -> DELIVER -> WAIT_NPC -> REQ. Also HALT and ERR.
//  REQ: imem_req_valid=1, addr=pc, held stable until imem_req_ready. On
//   handshake -> WAIT_RSP.
//  WAIT_RSP: on imem_rsp_valid, latch ir=imem_rsp_data -> DELIVER. A response
//   in any other state is ignored.
//  DELIVER: ir_valid=1. ir, pc and pc_plus stay stable until ir_ready. On
//   handshake -> WAIT_NPC.
//  WAIT_NPC: on npc_valid, pc<=npc.
//   - npc[1:0]==0: next state REQ.
//   - otherwise: misalign<=1, next state ERR.
//   npc_valid in any other state is ignored.
//  halt: sampled in every state. Takes effect once no imem transaction is open:
//   - REQ or WAIT_NPC: immediately.
//   - WAIT_RSP: after the response arrives.
//   - DELIVER: after the ir handshake.
//   Target state is HALT. halt wins over a simultaneous npc_valid.
//  HALT and ERR: absorbing, all valids 0, exit by reset only.
//  pc_plus is combinational pc+4 and wraps: 32'hFFFF_FFFC -> 32'h0.
//  Min latency npc_valid -> ir_valid is 3 cycles: ready same cycle as REQ
//   entry, rsp the next cycle.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//   - fetch_cnt increments on each ir handshake.
//   - mem_wait_cnt increments on each cycle spent in WAIT_RSP.
//   - Both wrap at 2^32.
//  FETCH_PERF_EN undefined: both outputs tied to 0, no counter flops.
// STRUCTURE
//  fetch_pkg:
//   - state enum (REQ, WAIT_RSP, DELIVER, WAIT_NPC, HALT, ERR)
//   - INSTR_BYTES=4
//   - NOP_INSTR=32'h0
//  Sub-module fetch_perf_ctr (two counters), instantiated only under
//   FETCH_PERF_EN. The FSM and PC register stay in the top module.
// TESTING
//  1 Reset, ready=1, rsp 1 cycle later with 0x1234 -> ir_valid, ir=0x1234,
//    pc=0, pc_plus=4.
//  2 ready low 5 cycles -> addr stable, req_valid held; with FETCH_PERF_EN,
//    mem_wait_cnt counts only post-accept cycles.
//  3 npc_valid with npc=0x40 in WAIT_NPC -> next req addr=0x40; npc_valid
//    during DELIVER -> ignored.
//  4 pc=0xFFFF_FFFC -> pc_plus=0; npc=0x42 -> misalign=1, ERR, no further
//    requests.
//  5 halt together with npc_valid -> HALT; halt in WAIT_RSP -> rsp consumed,
//    delivered, then HALT.
//  6 rst_n low during WAIT_RSP, late rsp arrives -> ignored, new req at
//    RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch unit: FSM state encoding,
// instruction size and the NOP word the instruction register resets to.
package fetch_pkg;

    typedef enum logic [2:0] {
        REQ      = 3'd0,
        WAIT_RSP = 3'd1,
        DELIVER  = 3'd2,
        WAIT_NPC = 3'd3,
        HALT     = 3'd4,
        ERR      = 3'd5
    } fetch_state_e;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Free-running fetch performance counters: retired fetches and cycles spent
// waiting for instruction memory. Both wrap at 2^32.
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        wait_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] mem_wait_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt    <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (fetch_inc) fetch_cnt    <= fetch_cnt + 32'd1;
            if (wait_inc)  mem_wait_cnt <= mem_wait_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC owner and single-outstanding instruction fetcher.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,
    input  logic              halt,
    output logic              misalign,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       mem_wait_cnt,
    output logic [2:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A producer raising valid keeps it and its payload stable until that edge;
    // ready may toggle freely. imem_rsp_valid and npc_valid are single-cycle
    // strobes with no back-pressure and are only honoured in their own state.

    fetch_state_e state, state_next;
    logic         halt_pend;
    logic         halt_eff;
    logic         load_ir;
    logic         load_pc;
    logic         set_misalign;

    // halt may be a pulse; remember it so it still lands after an open transaction.
    assign halt_eff = halt | halt_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= REQ;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        ir_valid       = 1'b0;
        load_ir        = 1'b0;
        load_pc        = 1'b0;
        set_misalign   = 1'b0;
        case (state)
            REQ: begin
                if (halt_eff) begin
                    state_next = HALT;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    load_ir    = 1'b1;
                    state_next = DELIVER;
                end
            end
            DELIVER: begin
                ir_valid = 1'b1;
                if (ir_ready) state_next = halt_eff ? HALT : WAIT_NPC;
            end
            WAIT_NPC: begin
                if (halt_eff) begin
                    state_next = HALT;
                end else if (npc_valid) begin
                    load_pc = 1'b1;
                    if (npc[1:0] != 2'b00) begin
                        set_misalign = 1'b1;
                        state_next   = ERR;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            HALT:    state_next = HALT;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= NOP_INSTR;
            misalign  <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            if (halt)         halt_pend <= 1'b1;
            if (load_pc)      pc        <= npc;
            if (load_ir)      ir        <= imem_rsp_data;
            if (set_misalign) misalign  <= 1'b1;
        end
    end

    assign imem_req_addr = pc;
    assign pc_plus       = pc + ADDR_W'(INSTR_BYTES);
    assign state_dbg     = state;

`ifdef FETCH_PERF_EN
    logic ir_hs;
    logic in_wait_rsp;

    assign ir_hs       = ir_valid & ir_ready;
    assign in_wait_rsp = (state == WAIT_RSP);

    fetch_perf_ctr u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_inc    (ir_hs),
        .wait_inc     (in_wait_rsp),
        .fetch_cnt    (fetch_cnt),
        .mem_wait_cnt (mem_wait_cnt)
    );
`else
    assign fetch_cnt    = '0;
    assign mem_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: transaction-level PC/instruction model plus
// directed and randomized fetch sequences.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        npc_valid = 1'b0;
    logic [31:0] npc = '0;
    logic        halt = 1'b0;
    logic        misalign;
    logic [31:0] fetch_cnt;
    logic [31:0] mem_wait_cnt;
    logic [2:0]  state_dbg;

    // reference model
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] last_ir;
    logic        exp_misalign;
    logic [31:0] exp_fetch;
    logic [31:0] exp_wait;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .halt           (halt),
        .misalign       (misalign),
        .fetch_cnt      (fetch_cnt),
        .mem_wait_cnt   (mem_wait_cnt),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        ir_ready = 1'b0; npc_valid = 1'b0; npc = '0; halt = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        exp_pc = RESET_PC; exp_misalign = 1'b0; exp_fetch = '0; exp_wait = '0; last_ir = NOP_INSTR;
        exp_q.delete();
    endtask

    // One fetch: hold ready low rdly cycles, respond sdly cycles after accept.
    task automatic fetch_one(input int rdly, input int sdly, input logic [31:0] data);
        logic [31:0] e;
        for (int i = 0; i <= rdly; i++) begin
            imem_req_ready = (i == rdly);
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
                n_errors++;
                $display("FAIL req_hold cyc=%0d valid=%b addr=%h expected valid=1 addr=%h", i, imem_req_valid, imem_req_addr, exp_pc);
            end
            tick;
        end
        imem_req_ready = 1'b0;
        repeat (sdly) tick;
        imem_rsp_valid = 1'b1; imem_rsp_data = data; exp_q.push_back(data);
        tick;
        imem_rsp_valid = 1'b0; imem_rsp_data = $urandom();
        exp_wait += 32'(sdly + 1);
        e = exp_q.pop_front();
        last_ir = e;
        n_checks++;
        if (ir_valid !== 1'b1 || ir !== e) begin
            n_errors++;
            $display("FAIL deliver ir_valid=%b ir=%h expected 1 %h", ir_valid, ir, e);
        end
        n_checks++;
        if (pc !== exp_pc || pc_plus !== exp_pc + 32'd4) begin
            n_errors++;
            $display("FAIL deliver_pc pc=%h pc_plus=%h expected %h %h", pc, pc_plus, exp_pc, exp_pc + 32'd4);
        end
    endtask

    task automatic accept_ir(input int stall);
        repeat (stall) begin
            tick;
            n_checks++;
            if (ir_valid !== 1'b1 || ir !== last_ir || pc !== exp_pc) begin
                n_errors++;
                $display("FAIL ir_hold ir_valid=%b ir=%h pc=%h expected 1 %h %h", ir_valid, ir, pc, last_ir, exp_pc);
            end
        end
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;
        exp_fetch++;
        n_checks++;
        if (ir_valid !== 1'b0 || imem_req_valid !== 1'b0 || state_dbg !== WAIT_NPC) begin
            n_errors++;
            $display("FAIL wait_npc ir_valid=%b req_valid=%b state=%0d expected 0 0 %0d", ir_valid, imem_req_valid, state_dbg, WAIT_NPC);
        end
    endtask

    task automatic send_npc(input logic [31:0] v);
        npc = v; npc_valid = 1'b1;
        tick;
        npc_valid = 1'b0;
        exp_pc = v;
        if (v[1:0] != 2'b00) exp_misalign = 1'b1;
        n_checks++;
        if (pc !== exp_pc || misalign !== exp_misalign) begin
            n_errors++;
            $display("FAIL npc pc=%h misalign=%b expected %h %b", pc, misalign, exp_pc, exp_misalign);
        end
    endtask

    task automatic check_perf(input string tag);
        logic [31:0] ef, ew;
`ifdef FETCH_PERF_EN
        ef = exp_fetch; ew = exp_wait;
`else
        ef = '0; ew = '0;
`endif
        n_checks++;
        if (fetch_cnt !== ef || mem_wait_cnt !== ew) begin
            n_errors++;
            $display("FAIL perf_%s fetch_cnt=%0d mem_wait_cnt=%0d expected %0d %0d", tag, fetch_cnt, mem_wait_cnt, ef, ew);
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++;
        if (state_dbg !== REQ || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || ir_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctl state=%0d req_valid=%b addr=%h ir_valid=%b expected %0d 1 %h 0", state_dbg, imem_req_valid, imem_req_addr, ir_valid, REQ, RESET_PC);
        end
        n_checks++;
        if (ir !== NOP_INSTR || pc !== RESET_PC || pc_plus !== RESET_PC + 32'd4 || misalign !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data ir=%h pc=%h pc_plus=%h misalign=%b expected 0 %h %h 0", ir, pc, pc_plus, misalign, RESET_PC, RESET_PC + 32'd4);
        end
        n_checks++;
        if (fetch_cnt !== 32'd0 || mem_wait_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_perf fetch_cnt=%0d mem_wait_cnt=%0d expected 0 0", fetch_cnt, mem_wait_cnt);
        end
    endtask

    task automatic test_basic;
        do_reset;
        fetch_one(0, 0, 32'h0000_1234);
        accept_ir(0);
        check_perf("basic");
    endtask

    task automatic test_ready_stall;
        do_reset;
        fetch_one(5, 2, $urandom());
        check_perf("stall");
        accept_ir(1);
        check_perf("stall_done");
    endtask

    task automatic test_npc_redirect;
        do_reset;
        fetch_one(0, 0, $urandom());
        npc = 32'h0000_0080; npc_valid = 1'b1;
        tick;
        npc_valid = 1'b0;
        n_checks++;
        if (ir_valid !== 1'b1 || pc !== exp_pc || state_dbg !== DELIVER) begin
            n_errors++;
            $display("FAIL npc_in_deliver ir_valid=%b pc=%h state=%0d expected 1 %h %0d", ir_valid, pc, state_dbg, exp_pc, DELIVER);
        end
        accept_ir(0);
        send_npc(32'h0000_0040);
        fetch_one(0, 0, $urandom());
        accept_ir(0);
    endtask

    task automatic test_wrap_misalign;
        do_reset;
        fetch_one(0, 0, $urandom());
        accept_ir(0);
        send_npc(32'hFFFF_FFFC);
        fetch_one(1, 1, $urandom());
        n_checks++;
        if (pc_plus !== 32'h0000_0000) begin
            n_errors++;
            $display("FAIL pc_plus_wrap pc_plus=%h expected 00000000", pc_plus);
        end
        accept_ir(0);
        send_npc(32'h0000_0042);
        imem_req_ready = 1'b1;
        npc = 32'h0000_0100; npc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++;
            if (state_dbg !== ERR || imem_req_valid !== 1'b0 || ir_valid !== 1'b0 || pc !== 32'h0000_0042 || misalign !== 1'b1) begin
                n_errors++;
                $display("FAIL err_absorb state=%0d req_valid=%b ir_valid=%b pc=%h misalign=%b expected %0d 0 0 00000042 1", state_dbg, imem_req_valid, ir_valid, pc, misalign, ERR);
            end
        end
        imem_req_ready = 1'b0; npc_valid = 1'b0;
    endtask

    task automatic test_halt;
        // halt together with npc_valid in WAIT_NPC
        do_reset;
        fetch_one(0, 0, $urandom());
        accept_ir(0);
        npc = 32'h0000_0040; npc_valid = 1'b1; halt = 1'b1;
        tick;
        npc_valid = 1'b0; halt = 1'b0; imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (state_dbg !== HALT || imem_req_valid !== 1'b0 || ir_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL halt_npc state=%0d req_valid=%b ir_valid=%b expected %0d 0 0", state_dbg, imem_req_valid, ir_valid, HALT);
            end
            tick;
        end
        imem_req_ready = 1'b0;
        // halt pulse while waiting for the response
        do_reset;
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0; halt = 1'b1;
        tick;
        halt = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
        tick;
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (ir_valid !== 1'b1 || ir !== 32'hCAFE_F00D) begin
            n_errors++;
            $display("FAIL halt_rsp_deliver ir_valid=%b ir=%h expected 1 cafef00d", ir_valid, ir);
        end
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0; imem_req_ready = 1'b1;
        tick;
        n_checks++;
        if (state_dbg !== HALT || imem_req_valid !== 1'b0 || ir_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_after_rsp state=%0d req_valid=%b ir_valid=%b expected %0d 0 0", state_dbg, imem_req_valid, ir_valid, HALT);
        end
        imem_req_ready = 1'b0;
    endtask

    task automatic test_reset_inflight;
        do_reset;
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== REQ || ir_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset state=%0d ir_valid=%b expected %0d 0", state_dbg, ir_valid, REQ);
        end
        tick;
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick;
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (state_dbg !== REQ || ir_valid !== 1'b0 || ir !== NOP_INSTR || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_errors++;
            $display("FAIL late_rsp state=%0d ir_valid=%b ir=%h req_valid=%b addr=%h expected %0d 0 0 1 %h", state_dbg, ir_valid, ir, imem_req_valid, imem_req_addr, REQ, RESET_PC);
        end
    endtask

    task automatic test_random;
        logic [31:0] v;
        do_reset;
        for (int n = 0; n < 25; n++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom());
            accept_ir($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) tick;
            v = $urandom() & 32'hFFFF_FFFC;
            send_npc(v);
        end
        check_perf("random");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ready_stall;
        test_npc_redirect;
        test_wrap_misalign;
        test_halt;
        test_reset_inflight;
        test_random;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
